// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one memory port between weight buffer (rd), decompressor (rd), compressor (wr).
// Latency: req sampled in IDLE at N -> mem_req at N+1 -> mem_valid at N+1+L -> ack at N+2+L.
// Backpressure: one transaction outstanding; requesters hold req/addr/wdata until their single-cycle ack.
//
// Ports: clk/rst_n (async active-low), flush (sync abort, pointer back to wb);
//        wb_*/dc_* read requesters with ack pulse and rdata; cp_* write requester with ack pulse;
//        mem_* single-cycle command strobe out, mem_valid/mem_rdata response in; busy while not IDLE.
// Optional macro MEM_ARB_PERF_CNT_EN adds saturating counters wb_cnt, dc_cnt, cp_cnt, stall_cnt.
module mem_req_arbiter #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wb_req,
    input  logic [ADDR_W-1:0] wb_addr,
    output logic              wb_ack,
    output logic [DATA_W-1:0] wb_rdata,
    input  logic              dc_req,
    input  logic [ADDR_W-1:0] dc_addr,
    output logic              dc_ack,
    output logic [DATA_W-1:0] dc_rdata,
    input  logic              cp_req,
    input  logic [ADDR_W-1:0] cp_addr,
    input  logic [DATA_W-1:0] cp_wdata,
    output logic              cp_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [15:0]       wb_cnt,
    output logic [15:0]       dc_cnt,
    output logic [15:0]       cp_cnt,
    output logic [15:0]       stall_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t     state, state_nxt;
    logic [1:0] ptr, ptr_nxt;
    logic [1:0] gnt, gnt_nxt;
    logic [2:0] req_vec;
    logic       grant_vld;
    logic [1:0] grant_idx;
    logic [1:0] cand1, cand2;
    logic       lat_en;
    logic       cap_en;
    logic       we_q;

    assign req_vec = {cp_req, dc_req, wb_req};

    // Successor modulo 3 over requester indices 0..2.
    function automatic logic [1:0] nxt3(input logic [1:0] p);
        case (p)
            2'd0:    return 2'd1;
            2'd1:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    // Cyclic search starting at the pointer: ptr, ptr+1, ptr+2.
    assign cand1 = nxt3(ptr);
    assign cand2 = nxt3(cand1);

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = ptr;
        if (req_vec[ptr]) begin
            grant_vld = 1'b1;
            grant_idx = ptr;
        end else if (req_vec[cand1]) begin
            grant_vld = 1'b1;
            grant_idx = cand1;
        end else if (req_vec[cand2]) begin
            grant_vld = 1'b1;
            grant_idx = cand2;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        gnt_nxt   = gnt;
        lat_en    = 1'b0;
        cap_en    = 1'b0;
        if (flush) begin
            // Abort wins over everything, including a response arriving this cycle.
            state_nxt = IDLE;
            ptr_nxt   = 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        gnt_nxt   = grant_idx;
                        ptr_nxt   = nxt3(grant_idx);
                        lat_en    = 1'b1;
                        state_nxt = ISSUE;
                    end
                end
                ISSUE: state_nxt = WAIT;
                WAIT: begin
                    if (mem_valid) begin
                        cap_en    = 1'b1;
                        state_nxt = RESP;
                    end
                end
                RESP:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            gnt       <= 2'd0;
            we_q      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wb_rdata  <= '0;
            dc_rdata  <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            gnt   <= gnt_nxt;
            if (lat_en) begin
                case (grant_idx)
                    2'd0: begin
                        mem_addr <= wb_addr;
                        we_q     <= 1'b0;
                    end
                    2'd1: begin
                        mem_addr <= dc_addr;
                        we_q     <= 1'b0;
                    end
                    default: begin
                        mem_addr  <= cp_addr;
                        mem_wdata <= cp_wdata;
                        we_q      <= 1'b1;
                    end
                endcase
            end
            if (cap_en) begin
                if (gnt == 2'd0) wb_rdata <= mem_rdata;
                if (gnt == 2'd1) dc_rdata <= mem_rdata;
            end
        end
    end

    assign mem_req = (state == ISSUE);
    assign mem_we  = mem_req & we_q;
    assign busy    = (state != IDLE);
    assign wb_ack  = (state == RESP) && (gnt == 2'd0);
    assign dc_ack  = (state == RESP) && (gnt == 2'd1);
    assign cp_ack  = (state == RESP) && (gnt == 2'd2);

`ifdef MEM_ARB_PERF_CNT_EN
    logic stall;
    assign stall = (|req_vec) && (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_cnt    <= '0;
            dc_cnt    <= '0;
            cp_cnt    <= '0;
            stall_cnt <= '0;
        end else if (flush) begin
            wb_cnt    <= '0;
            dc_cnt    <= '0;
            cp_cnt    <= '0;
            stall_cnt <= '0;
        end else begin
            if (wb_ack && wb_cnt != 16'hFFFF)       wb_cnt    <= wb_cnt + 16'd1;
            if (dc_ack && dc_cnt != 16'hFFFF)       dc_cnt    <= dc_cnt + 16'd1;
            if (cp_ack && cp_cnt != 16'hFFFF)       cp_cnt    <= cp_cnt + 16'd1;
            if (stall && stall_cnt != 16'hFFFF)     stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
module tb_mem_req_arbiter;
    localparam int DATA_W = 64;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst_n, flush;
    logic              wb_req, dc_req, cp_req;
    logic [ADDR_W-1:0] wb_addr, dc_addr, cp_addr;
    logic [DATA_W-1:0] cp_wdata;
    logic              wb_ack, dc_ack, cp_ack;
    logic [DATA_W-1:0] wb_rdata, dc_rdata;
    logic              mem_req, mem_we, mem_valid, busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
`ifdef MEM_ARB_PERF_CNT_EN
    logic [15:0]       wb_cnt, dc_cnt, cp_cnt, stall_cnt;
`endif

    always #5 clk = ~clk;

    mem_req_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .wb_req(wb_req), .wb_addr(wb_addr), .wb_ack(wb_ack), .wb_rdata(wb_rdata),
        .dc_req(dc_req), .dc_addr(dc_addr), .dc_ack(dc_ack), .dc_rdata(dc_rdata),
        .cp_req(cp_req), .cp_addr(cp_addr), .cp_wdata(cp_wdata), .cp_ack(cp_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_valid(mem_valid), .mem_rdata(mem_rdata), .busy(busy)
`ifdef MEM_ARB_PERF_CNT_EN
        , .wb_cnt(wb_cnt), .dc_cnt(dc_cnt), .cp_cnt(cp_cnt), .stall_cnt(stall_cnt)
`endif
    );

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    typedef struct {
        int                id;
        logic [DATA_W-1:0] rdata;
    } ack_t;

    cmd_t              cmd_q[$];
    ack_t              ack_q[$];
    int                n_cmp = 0;
    int                n_bad = 0;
    int                pend[3];
    logic [DATA_W-1:0] last_rd[2];
    int                mem_lat = 3;
    bit                mem_auto = 1'b1;
    bit                gap_chk = 1'b0;
    int                last_req = -1;
    bit                done = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory contents: a distinctive value per address, 0xAA at 0x100.
    function automatic logic [DATA_W-1:0] mem_data(input logic [ADDR_W-1:0] a);
        if (a == 32'h100) return 64'hAA;
        return {a, ~a};
    endfunction

    task automatic exp_read(input int id, input logic [ADDR_W-1:0] a);
        cmd_t c;
        ack_t k;
        c.we = 1'b0; c.addr = a; c.wdata = '0;
        k.id = id;   k.rdata = mem_data(a);
        cmd_q.push_back(c);
        ack_q.push_back(k);
        last_rd[id] = k.rdata;
    endtask

    task automatic exp_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        cmd_t c;
        ack_t k;
        c.we = 1'b1; c.addr = a; c.wdata = d;
        k.id = 2;    k.rdata = '0;
        cmd_q.push_back(c);
        ack_q.push_back(k);
    endtask

    task automatic drop_req(input int id);
        case (id)
            0: wb_req = 1'b0;
            1: dc_req = 1'b0;
            default: cp_req = 1'b0;
        endcase
    endtask

    // Memory model, requester agent and scoreboard checker, all sampled on the falling edge.
    task automatic monitor();
        int                cnt = 0;
        int                cyc = 0;
        logic [DATA_W-1:0] resp = '0;
        logic              vld_prev;
        cmd_t              c;
        ack_t              k;
        int                id;
        while (!done) begin
            @(negedge clk);
            cyc++;
            vld_prev = mem_valid;
            if (!rst_n) cnt = 0;
            if (wb_ack || dc_ack || cp_ack) begin
                id = wb_ack ? 0 : (dc_ack ? 1 : 2);
                check("ack_onehot", {61'd0, wb_ack, dc_ack, cp_ack}, 64'(1 << (2 - id)));
                check("ack_after_mem_valid", {63'd0, vld_prev}, 64'd1);
                if (ack_q.size() == 0) begin
                    check("unexpected_ack", 64'(id), 64'hFFFF);
                end else begin
                    k = ack_q.pop_front();
                    check("ack_id", 64'(id), 64'(k.id));
                    if (id == 0) check("wb_rdata", wb_rdata, k.rdata);
                    if (id == 1) check("dc_rdata", dc_rdata, k.rdata);
                end
                pend[id]--;
                if (pend[id] <= 0) drop_req(id);
            end
            check("mem_we_without_req", {63'd0, mem_we & ~mem_req}, 64'd0);
            if (mem_auto) begin
                mem_valid = 1'b0;
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        mem_valid = 1'b1;
                        mem_rdata = resp;
                    end
                end
            end
            if (mem_req) begin
                if (cmd_q.size() == 0) begin
                    check("unexpected_mem_req", {32'd0, mem_addr}, 64'hFFFF_FFFF_FFFF);
                end else begin
                    c = cmd_q.pop_front();
                    check("cmd_we", {63'd0, mem_we}, {63'd0, c.we});
                    check("cmd_addr", {32'd0, mem_addr}, {32'd0, c.addr});
                    if (c.we) check("cmd_wdata", mem_wdata, c.wdata);
                end
                if (gap_chk && last_req >= 0)
                    check("req_gap_ge_L_plus_3", {63'd0, (cyc - last_req) >= mem_lat + 3}, 64'd1);
                last_req = cyc;
                resp = mem_we ? 64'hDEAD_BEEF : mem_data(mem_addr);
                if (mem_auto) cnt = mem_lat;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((cmd_q.size() != 0 || ack_q.size() != 0 || busy) && t < 300) begin
            step();
            t++;
        end
        check("idle_timeout", {63'd0, t >= 300}, 64'd0);
        cmd_q.delete();
        ack_q.delete();
    endtask

    task automatic wait_mem_req(input string name);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!mem_req && t < 50);
        check(name, {63'd0, mem_req}, 64'd1);
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_ctl"}, {58'd0, wb_ack, dc_ack, cp_ack, mem_req, mem_we, busy}, 64'd0);
        check({tag, "_mem_addr"}, {32'd0, mem_addr}, 64'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 64'd0);
        check({tag, "_wb_rdata"}, wb_rdata, 64'd0);
        check({tag, "_dc_rdata"}, dc_rdata, 64'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        last_rd[0] = '0;
        last_rd[1] = '0;
    endtask

    task automatic quiet_check(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check(name, {61'd0, wb_ack | dc_ack | cp_ack, busy, mem_req}, 64'd0);
        end
    endtask

    task automatic stimulus();
        // Reset state
        #12;
        chk_zero("reset");
        step();
        rst_n = 1'b1;
        step();
        step();

        // Single read, L=3: mem_req at N+1, ack at N+5, busy N+1..N+5
        mem_lat = 3;
        wb_addr = 32'h100;
        wb_req  = 1'b1;
        pend[0] = 1;
        exp_read(0, 32'h100);
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            check($sformatf("t1_busy_c%0d", c), {63'd0, busy}, {63'd0, c >= 1 && c <= 5});
            check($sformatf("t1_mem_req_c%0d", c), {63'd0, mem_req}, {63'd0, c == 1});
            check($sformatf("t1_wb_ack_c%0d", c), {63'd0, wb_ack}, {63'd0, c == 5});
        end
        wait_idle();

        // Contention from reset: wb, dc, cp, wb with L=2
        mem_lat  = 2;
        @(negedge clk);
        rst_n    = 1'b0;
        wb_addr  = 32'h200;
        dc_addr  = 32'h300;
        cp_addr  = 32'h400;
        cp_wdata = 64'h5555;
        wb_req = 1'b1; dc_req = 1'b1; cp_req = 1'b1;
        pend[0] = 2; pend[1] = 1; pend[2] = 1;
        exp_read(0, 32'h200);
        exp_read(1, 32'h300);
        exp_write(32'h400, 64'h5555);
        exp_read(0, 32'h200);
        last_req = -1;
        gap_chk  = 1'b1;
        step();
        rst_n = 1'b1;
        wait_idle();
        gap_chk = 1'b0;

        // Compressor write leaves read data untouched
        cp_addr  = 32'h40;
        cp_wdata = 64'h1234;
        cp_req   = 1'b1;
        pend[2]  = 1;
        exp_write(32'h40, 64'h1234);
        wait_idle();
        check("t3_wb_rdata_kept", wb_rdata, last_rd[0]);
        check("t3_dc_rdata_kept", dc_rdata, last_rd[1]);

        // Pointer fairness: dc held, wb arrives during dc's first transaction
        pulse_reset();
        dc_addr = 32'h500;
        wb_addr = 32'h600;
        dc_req  = 1'b1;
        pend[1] = 2;
        exp_read(1, 32'h500);
        exp_read(0, 32'h600);
        exp_read(1, 32'h500);
        step();
        step();
        wb_req  = 1'b1;
        pend[0] = 1;
        wait_idle();

        // Flush in WAIT: no ack, busy drops, next grant starts at wb
        mem_auto  = 1'b0;
        mem_valid = 1'b0;
        dc_addr   = 32'h700;
        dc_req    = 1'b1;
        pend[1]   = 1;
        begin
            cmd_t c;
            c.we = 1'b0; c.addr = 32'h700; c.wdata = '0;
            cmd_q.push_back(c);
        end
        wait_mem_req("t5_mem_req_seen");
        step();
        flush   = 1'b1;
        dc_req  = 1'b0;
        pend[1] = 0;
        step();
        flush = 1'b0;
        @(negedge clk);
        check("t5_busy_after_flush", {63'd0, busy}, 64'd0);
        step();
        mem_valid = 1'b1;
        mem_rdata = 64'h99;
        step();
        mem_valid = 1'b0;
        quiet_check("t5_no_ack", 4);
        check("t5_dc_rdata_kept", dc_rdata, last_rd[1]);
        mem_auto = 1'b1;
        wb_addr  = 32'h800;
        dc_addr  = 32'h900;
        cp_addr  = 32'hA00;
        cp_wdata = 64'h77;
        pend[0] = 1; pend[1] = 1; pend[2] = 1;
        exp_read(0, 32'h800);
        exp_read(1, 32'h900);
        exp_write(32'hA00, 64'h77);
        wb_req = 1'b1; dc_req = 1'b1; cp_req = 1'b1;
        wait_idle();

        // Asynchronous reset mid-WAIT, then a stray response
        mem_auto = 1'b0;
        wb_addr  = 32'hB00;
        wb_req   = 1'b1;
        pend[0]  = 1;
        begin
            cmd_t c;
            c.we = 1'b0; c.addr = 32'hB00; c.wdata = '0;
            cmd_q.push_back(c);
        end
        wait_mem_req("t6_mem_req_seen");
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("t6_async_reset");
        wb_req  = 1'b0;
        pend[0] = 0;
        step();
        rst_n = 1'b1;
        step();
        mem_valid = 1'b1;
        mem_rdata = 64'h55;
        step();
        mem_valid = 1'b0;
        quiet_check("t6_stray_valid", 4);
        mem_auto = 1'b1;
        step();
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0;
        wb_req = 1'b0; dc_req = 1'b0; cp_req = 1'b0;
        wb_addr = '0; dc_addr = '0; cp_addr = '0; cp_wdata = '0;
        mem_valid = 1'b0; mem_rdata = '0;
        pend[0] = 0; pend[1] = 0; pend[2] = 0;
        last_rd[0] = '0; last_rd[1] = '0;
        fork
            monitor();
            begin
                stimulus();
                done = 1'b1;
            end
        join
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
Shares the single accelerator memory port between the weight buffer (read), the decompressor (read) and the compressor (write).
- Round-robin arbitration, one outstanding transaction at a time.
- Drives address, write data and enable to the memory and routes the returned read data back to the granted requester.
- Sits between the layer controller's requesters and the testbench/memory model.

Parameters:
DATA_W, 64, memory data width in bits (MEM_BANDWIDTH*8)
ADDR_W, 32, memory address width in bits

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous abort of the current transaction, pulsed by the controller at layer start
wb_req  input  1  weight buffer read request, level
wb_addr  input  ADDR_W  weight buffer read address
wb_ack  output  1  weight buffer response pulse
wb_rdata  output  DATA_W  read data to the weight buffer
dc_req  input  1  decompressor read request, level
dc_addr  input  ADDR_W  decompressor read address
dc_ack  output  1  decompressor response pulse
dc_rdata  output  DATA_W  read data to the decompressor
cp_req  input  1  compressor write request, level
cp_addr  input  ADDR_W  compressor write address
cp_wdata  input  DATA_W  compressor write data
cp_ack  output  1  compressor write-done pulse
mem_req  output  1  memory command strobe, one cycle
mem_we  output  1  1 = write, 0 = read; qualified by mem_req
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_valid  input  1  memory response: read data valid, or write complete
mem_rdata  input  DATA_W  memory read data
busy  output  1  transaction outstanding

Behaviour:
- Requester indices are fixed: 0 = wb, 1 = dc, 2 = cp.
- Requester contract: hold req, addr and wdata stable until its ack. Ack is a single-cycle pulse. A requester wanting another transaction keeps req high; it is re-arbitrated in IDLE.
- Reset values: all outputs 0, state IDLE, round-robin pointer = 0 (wb highest).
- FSM: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req is high, grant the first requesting index at or after the pointer, searching cyclically.
  - Latch the grantee's addr, wdata (cp only) and we (1 only for cp) into registers.
  - Set pointer = grantee+1 mod 3. Go to ISSUE.
  - No req: stay in IDLE.
- ISSUE: mem_req=1 for exactly one cycle with the latched mem_addr/mem_we/mem_wdata, then go to WAIT.
- WAIT: on mem_valid, register mem_rdata into the grantee's rdata and go to RESP.
- RESP:
  - Pulse the grantee's ack for one cycle; the grantee's rdata is valid that cycle and holds until that requester's next response.
  - Return to IDLE. Arbitration resumes the following cycle, so ack and the next grant never share a cycle.
- Latency: req sampled in IDLE at cycle N → mem_req at N+1 → mem_valid at N+1+L (L≥1) → ack at N+2+L.
- mem_addr/mem_we/mem_wdata hold their last value outside ISSUE. mem_we=0 whenever mem_req=0.
- busy = 1 in ISSUE, WAIT and RESP.
- mem_valid in IDLE or ISSUE is ignored: no ack, no state change.
- mem_valid and flush in the same cycle: flush wins, no ack.
- A requester dropping req while granted is a protocol error. The transaction still completes and the ack is still issued.
- flush: returns the FSM to IDLE from any state and sets pointer=0. No ack for the aborted transaction. Rdata registers are kept.
- Reset mid-transaction: same as flush, plus all outputs cleared. Any later mem_valid while in IDLE is ignored.

Optional Feature:
Macro MEM_ARB_PERF_CNT_EN.
- Defined: adds outputs wb_cnt, dc_cnt, cp_cnt (16 bits each) and stall_cnt (16 bits).
  - Each requester count increments on that requester's ack.
  - stall_cnt increments every cycle in which some req is high and the FSM is not IDLE.
  - All counters saturate at 0xFFFF, are cleared by reset or flush, and reset to 0.
- Undefined: these ports and counters do not exist. Arbitration behaviour is identical either way.

Test Plan:
- Single read: wb_req=1, wb_addr=0x100, memory L=3 returns 0xAA → mem_req=1/mem_we=0/mem_addr=0x100 at N+1; wb_ack=1 with wb_rdata=0xAA at N+5; busy=1 from N+1 to N+5.
- Contention: wb, dc, cp all asserted from reset and held → grants in order wb, dc, cp, wb; each mem_req is ≥ L+3 cycles after the previous one.
- Compressor write: cp_addr=0x40, cp_wdata=0x1234 → mem_we=1, mem_wdata=0x1234, mem_addr=0x40; cp_ack 1 cycle after mem_valid; dc_rdata and wb_rdata unchanged.
- Pointer fairness: dc held high continuously while wb pulses one request after dc's first grant → next grant goes to wb, then dc.
- Flush in WAIT: flush during WAIT, then mem_valid 2 cycles later → no ack at all, busy=0 the cycle after flush, next arbitration starts with wb.
- Async reset mid-WAIT: rst_n low during WAIT → all outputs 0 immediately; after release, a stray mem_valid produces no ack.
